serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder. It produces one bit per clock, LSB first.

---
 rtl/serial_adder_full_adder.sv | 31 +++
 rtl/serial_adder_half_adder.sv | 12 +
 rtl/serial_adder.sv | 114 +++++++++++
 tb/tb_serial_adder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_full_adder.sv
// Full adder cell made from two half adders; the two partial carries are ORed.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .i_a (a),
    .i_b (b),
    .o_s (w_s1),
    .o_c (w_c1)
  );

  half_adder u_ha1 (
    .i_a (w_s1),
    .i_b (cin),
    .o_s (s),
    .o_c (w_c2)
  );

  // Both partial carries can never be high together, so OR is exact.
  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_half_adder.sv
// Half adder cell: sum and carry of two input bits.
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// sum/cout are registered and only update on the last-bit edge or reset.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one operand bit added per cycle
  // DONE  | single cycle, result just became valid
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

  localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a_sr;
  logic [WIDTH-1:0]   r_b_sr;
  logic [WIDTH-1:0]   r_s_sr;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_s;
  logic               w_co;
  logic               w_accept;
  logic               w_run;
  logic               w_last;
  logic [WIDTH-1:0]   w_s_shift;

  full_adder u_fa (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_co)
  );

  assign w_run     = (r_state == ST_RUN);
  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last    = w_run && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_s_shift = {w_s, r_s_sr[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_s_sr  <= w_s_shift;
      r_carry <= w_co;
      r_cnt   <= r_cnt + CNT_W'(1);
      // Final bit bypasses S_sr so the result lands on the same edge.
      if (w_last) begin
        r_sum  <= w_s_shift;
        r_cout <= w_co;
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic model.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic         start4;
  logic [3:0]   a4;
  logic [3:0]   b4;
  logic         busy4;
  logic         done4;
  logic [3:0]   sum4;
  logic         cout4;

  int n_total = 0;
  int n_bad   = 0;

  logic [W-1:0] exp_s = '0;
  logic         exp_c = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launches x+y (start may already be accepted from a DONE cycle) and checks
  // busy for W cycles, the held previous result, then the done cycle.
  task automatic add_check(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] full;
    full  = {1'b0, x} + {1'b0, y};
    a     = x;
    b     = y;
    start = 1'b1;
    step();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    for (int i = 0; i < W; i++) begin
      check_eq("busy_run", busy, 1);
      check_eq("done_run", done, 0);
      check_eq("sum_hold", sum, exp_s);
      check_eq("cout_hold", cout, exp_c);
      step();
    end
    exp_s = full[W-1:0];
    exp_c = full[W];
    check_eq("done_pulse", done, 1);
    check_eq("busy_done", busy, 0);
    check_eq("sum", sum, exp_s);
    check_eq("cout", cout, exp_c);
  endtask

  initial begin
    int ndone;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    start4 = 1'b0;
    a4     = '0;
    b4     = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_cout", cout, 0);
    step();

    add_check(8'h35, 8'h4A);
    step();
    check_eq("idle_after_done", done, 0);
    check_eq("idle_busy", busy, 0);
    add_check(8'hFF, 8'h01);
    step();
    add_check(8'hFF, 8'hFF);
    step();
    add_check(8'h00, 8'h00);
    step();

    // start pulsed mid-RUN must be ignored
    a = 8'h0C; b = 8'h22; start = 1'b1;
    step();
    ndone = 0;
    for (int i = 0; i < W + 6; i++) begin
      if (i == 2) begin
        start = 1'b1; a = 8'hAA; b = 8'h55;
      end else begin
        start = 1'b0;
      end
      step();
      if (done) ndone++;
    end
    check_eq("midrun_ndone", ndone, 1);
    check_eq("midrun_sum", sum, 8'h2E);
    check_eq("midrun_cout", cout, 0);
    exp_s = 8'h2E; exp_c = 1'b0;

    // reset during RUN aborts
    a = 8'h10; b = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_sum", sum, 0);
    check_eq("abort_cout", cout, 0);
    ndone = 0;
    for (int i = 0; i < W + 2; i++) begin
      step();
      if (done || busy) ndone++;
    end
    check_eq("abort_no_done", ndone, 0);
    exp_s = '0; exp_c = 1'b0;

    // back-to-back: start held through the DONE cycle
    add_check(8'h12, 8'h34);
    add_check(8'h80, 8'h80);
    step();

    // random operands, sometimes back-to-back
    for (int n = 0; n < 24; n++) begin
      add_check(W'($urandom), W'($urandom));
      if ($urandom_range(0, 1) == 0) step();
    end
    step();

    // narrow instance
    a4 = 4'h9; b4 = 4'h8; start4 = 1'b1;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("w4_busy", busy4, 1);
      check_eq("w4_done_low", done4, 0);
      step();
    end
    check_eq("w4_done", done4, 1);
    check_eq("w4_busy_low", busy4, 0);
    check_eq("w4_sum", sum4, 4'h1);
    check_eq("w4_cout", cout4, 1);
    step();
    check_eq("w4_done_once", done4, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
